// File: rtl/pcm_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pcm_uart_tx
// Description : Serialises 32-bit stereo PCM samples onto a UART line.
//               Each accepted sample is sent as four 8N1 bytes in the order
//               [23:16], [31:24], [7:0], [15:8], back-to-back with no idle
//               bits between them. Each bit lasts CLK_FREQ/BAUDRATE cycles.
//               Optional host flow control (cts) is checked before every
//               start bit.
// Config      : `define PCM_TX_FLOW_CTRL_EN enables cts flow control through
//               a 2-flop synchroniser. When it is undefined, cts is ignored.
// Ports       : clk          - system clock, rising edge
//               reset        - synchronous active-high reset
//               sample_in    - [31:16] left, [15:0] right PCM sample
//               sample_valid - sample_in holds a valid sample
//               sample_ready - block accepts a sample this cycle (IDLE)
//               cts          - host clear-to-send, asynchronous
//               tx           - UART serial output, idle high
//               busy         - a sample frame is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_uart_tx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUDRATE = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        cts,
    output logic        tx,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CTS = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_STOP     = 3'd4
    } state_t;

    state_t           r_state,    w_state_next;
    logic [31:0]      r_sample,   w_sample_next;
    logic [1:0]       r_byte_idx, w_byte_idx_next;
    logic [2:0]       r_bit_cnt,  w_bit_cnt_next;
    logic [CNT_W-1:0] r_clk_cnt,  w_clk_cnt_next;
    logic             w_clk_last;
    logic             w_cts_ok;
    logic [7:0]       w_cur_byte;

`ifdef PCM_TX_FLOW_CTRL_EN
    logic r_cts_meta;
    logic r_cts_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cts_meta <= 1'b0;
            r_cts_sync <= 1'b0;
        end else begin
            r_cts_meta <= cts;
            r_cts_sync <= r_cts_meta;
        end
    end

    assign w_cts_ok = r_cts_sync;
`else
    // cts is kept on the port for pin compatibility but has no effect.
    logic w_unused_cts;
    assign w_unused_cts = cts;
    assign w_cts_ok     = 1'b1;
`endif

    // Byte order on the wire: [23:16], [31:24], [7:0], [15:8].
    always_comb begin
        w_cur_byte = r_sample[23:16];
        case (r_byte_idx)
            2'd0: w_cur_byte = r_sample[23:16];
            2'd1: w_cur_byte = r_sample[31:24];
            2'd2: w_cur_byte = r_sample[7:0];
            2'd3: w_cur_byte = r_sample[15:8];
            default: w_cur_byte = r_sample[23:16];
        endcase
    end

    assign w_clk_last = (r_clk_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sample   <= 32'd0;
            r_byte_idx <= 2'd0;
            r_bit_cnt  <= 3'd0;
            r_clk_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sample   <= w_sample_next;
            r_byte_idx <= w_byte_idx_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_clk_cnt  <= w_clk_cnt_next;
        end
    end

    // WAIT_CTS doubles as the first cycle of the start bit once flow control
    // permits, so START only covers the remaining CLKS_PER_BIT-1 cycles. This
    // gives the 1-cycle acceptance-to-start latency and seamless bytes.
    always_comb begin
        w_state_next    = r_state;
        w_sample_next   = r_sample;
        w_byte_idx_next = r_byte_idx;
        w_bit_cnt_next  = r_bit_cnt;
        w_clk_cnt_next  = r_clk_cnt;
        tx              = 1'b1;
        busy            = (r_state != S_IDLE);
        sample_ready    = (r_state == S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (sample_valid) begin
                    w_state_next    = S_WAIT_CTS;
                    w_sample_next   = sample_in;
                    w_byte_idx_next = 2'd0;
                    w_bit_cnt_next  = 3'd0;
                    w_clk_cnt_next  = '0;
                end
            end

            S_WAIT_CTS: begin
                tx = ~w_cts_ok;
                if (w_cts_ok) begin
                    w_bit_cnt_next = 3'd0;
                    if (CLKS_PER_BIT == 1) begin
                        w_state_next   = S_DATA;
                        w_clk_cnt_next = '0;
                    end else begin
                        w_state_next   = S_START;
                        w_clk_cnt_next = C_CNT_ONE;
                    end
                end
            end

            S_START: begin
                tx = 1'b0;
                if (w_clk_last) begin
                    w_state_next   = S_DATA;
                    w_clk_cnt_next = '0;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + C_CNT_ONE;
                end
            end

            S_DATA: begin
                tx = w_cur_byte[r_bit_cnt];
                if (w_clk_last) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next   = S_STOP;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + C_CNT_ONE;
                end
            end

            S_STOP: begin
                tx = 1'b1;
                if (w_clk_last) begin
                    w_clk_cnt_next = '0;
                    if (r_byte_idx == 2'd3) begin
                        w_state_next    = S_IDLE;
                        w_byte_idx_next = 2'd0;
                    end else begin
                        w_state_next    = S_WAIT_CTS;
                        w_byte_idx_next = r_byte_idx + 2'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + C_CNT_ONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
